// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage controller.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Bit positions inside the 2-bit control_wb bundle
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam logic [1:0] WB_NONE = 2'b00;

endpackage

// File: rtl/mem_timeout_counter.sv
// WAIT-cycle counter: counts while enabled, raises hit on the last allowed cycle.
// A zero limit disables the hit flag entirely.
module mem_timeout_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit_o = (limit_i != '0) && (cnt_q == limit_i - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: one data-memory access per instruction over req/ready, stalls while busy,
// hands results to MEM/WB with a 1-cycle wb_valid. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [1:0]        control_wb_in,
    input  logic              memread_in,
    input  logic              memwrite_in,
    input  logic [ADDR_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [4:0]        write_reg_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [1:0]        control_wb_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [ADDR_W-1:0] alu_result_out,
    output logic [4:0]        write_reg_out,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wb_vld_q, wb_vld_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] alu_q, alu_d;
    logic [4:0]        wreg_q, wreg_d;
    logic              err_q, err_d;
    logic [1:0]        pend_ctrl_q, pend_ctrl_d;
    logic [4:0]        pend_reg_q, pend_reg_d;
    logic              pend_load_q, pend_load_d;

    logic mem_op;
    logic misalign;
    logic issue;
    logic to_hit;

    assign mem_op = memread_in | memwrite_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (alu_result_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign issue = (state_q == IDLE) && ex_valid && mem_op && !misalign;
    assign stall = issue || ((state_q == WAIT) && !dmem_ready && !to_hit);

    mem_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q == IDLE),
        .en_i    (state_q == WAIT),
        .limit_i (CNT_W'(TIMEOUT_CYCLES)),
        .hit_o   (to_hit)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_vld_d    = 1'b0;
        ctrl_d      = WB_NONE;
        rdata_d     = rdata_q;
        alu_d       = alu_q;
        wreg_d      = wreg_q;
        err_d       = 1'b0;
        pend_ctrl_d = pend_ctrl_q;
        pend_reg_d  = pend_reg_q;
        pend_load_d = pend_load_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!mem_op) begin
                        wb_vld_d = 1'b1;
                        ctrl_d   = control_wb_in;
                        alu_d    = alu_result_in;
                        wreg_d   = write_reg_in;
                    end else if (misalign) begin
                        // Rejected access still retires, but with no register write
                        wb_vld_d = 1'b1;
                        err_d    = 1'b1;
                        alu_d    = alu_result_in;
                        wreg_d   = write_reg_in;
                    end else begin
                        state_d     = WAIT;
                        req_d       = 1'b1;
                        we_d        = memwrite_in;
                        addr_d      = alu_result_in;
                        wdata_d     = write_data_in;
                        pend_ctrl_d = control_wb_in;
                        pend_reg_d  = write_reg_in;
                        pend_load_d = memread_in;
                    end
                end
            end
            WAIT: begin
                // Ready has priority over a timeout landing in the same cycle
                if (dmem_ready) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    wb_vld_d = 1'b1;
                    ctrl_d   = pend_ctrl_q;
                    alu_d    = addr_q;
                    wreg_d   = pend_reg_q;
                    if (pend_load_q) begin
                        rdata_d = dmem_rdata;
                    end
                end else if (to_hit) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    wb_vld_d = 1'b1;
                    err_d    = 1'b1;
                    alu_d    = addr_q;
                    wreg_d   = pend_reg_q;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_vld_q    <= 1'b0;
            ctrl_q      <= WB_NONE;
            rdata_q     <= '0;
            alu_q       <= '0;
            wreg_q      <= '0;
            err_q       <= 1'b0;
            pend_ctrl_q <= WB_NONE;
            pend_reg_q  <= '0;
            pend_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_vld_q    <= wb_vld_d;
            ctrl_q      <= ctrl_d;
            rdata_q     <= rdata_d;
            alu_q       <= alu_d;
            wreg_q      <= wreg_d;
            err_q       <= err_d;
            pend_ctrl_q <= pend_ctrl_d;
            pend_reg_q  <= pend_reg_d;
            pend_load_q <= pend_load_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign wb_valid       = wb_vld_q;
    assign control_wb_out = ctrl_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign write_reg_out  = wreg_q;
    assign mem_err        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT_CYCLES=4.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  control_wb_in;
    logic        memread_in;
    logic        memwrite_in;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic [4:0]  write_reg_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [1:0]  control_wb_out;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  write_reg_out;
    logic        mem_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .control_wb_in  (control_wb_in),
        .memread_in     (memread_in),
        .memwrite_in    (memwrite_in),
        .alu_result_in  (alu_result_in),
        .write_data_in  (write_data_in),
        .write_reg_in   (write_reg_in),
        .stall          (stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .control_wb_out (control_wb_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .write_reg_out  (write_reg_out),
        .mem_err        (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        control_wb_in = 2'b00;
        memread_in    = 1'b0;
        memwrite_in   = 1'b0;
        alu_result_in = '0;
        write_data_in = '0;
        write_reg_in  = '0;
        dmem_ready    = 1'b0;
        dmem_rdata    = '0;
    endtask

    // Presents one mem op, holds it while stalled, asserts ready in the n_wait-th cycle
    // after presentation, then checks the retire cycle.
    task automatic run_mem(input string tag, input bit is_store, input logic [1:0] ctrl,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rg, input int n_wait,
                           input logic [31:0] rd, input int exp_stalls);
        int stalls;
        stalls        = 0;
        ex_valid      = 1'b1;
        control_wb_in = ctrl;
        memread_in    = !is_store;
        memwrite_in   = is_store;
        alu_result_in = addr;
        write_data_in = wd;
        write_reg_in  = rg;
        for (int c = 0; c <= n_wait; c++) begin
            if (c == n_wait) begin
                dmem_ready = 1'b1;
                dmem_rdata = rd;
            end
            #1;
            if (stall) stalls++;
            if (c >= 1) begin
                chk({tag, "_req"}, dmem_req, 1);
                chk({tag, "_we"}, dmem_we, is_store);
                chk({tag, "_addr"}, dmem_addr, addr);
                if (is_store) chk({tag, "_wdata"}, dmem_wdata, wd);
            end
            tick();
        end
        idle_inputs();
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_wbv"}, wb_valid, 1);
        chk({tag, "_req_off"}, dmem_req, 0);
        chk({tag, "_err"}, mem_err, 0);
        chk({tag, "_ctrl"}, control_wb_out, ctrl);
        chk({tag, "_alu"}, alu_result_out, addr);
        chk({tag, "_wreg"}, write_reg_out, rg);
    endtask

    initial begin
        int req_cycles;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();

        chk("rst_req", dmem_req, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_ctrl", control_wb_out, 0);
        chk("rst_rdata", read_data_out, 0);
        chk("rst_alu", alu_result_out, 0);

        rst_n = 1'b1;
        tick();

        // ALU-only instruction, latency 1
        ex_valid      = 1'b1;
        control_wb_in = 2'b01;
        alu_result_in = 32'h0000_0010;
        write_reg_in  = 5'd3;
        #1;
        chk("alu_stall", stall, 0);
        tick();
        idle_inputs();
        chk("alu_wbv", wb_valid, 1);
        chk("alu_res", alu_result_out, 32'h10);
        chk("alu_ctrl", control_wb_out, 2'b01);
        chk("alu_wreg", write_reg_out, 5'd3);
        chk("alu_req", dmem_req, 0);
        tick();
        chk("bubble_wbv", wb_valid, 0);
        chk("bubble_ctrl", control_wb_out, 2'b00);
        chk("bubble_hold", alu_result_out, 32'h10);

        // Load, ready on third cycle
        run_mem("ld", 1'b0, 2'b11, 32'h100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF, 3);
        chk("ld_rdata", read_data_out, 32'hDEAD_BEEF);
        tick();
        chk("ld_wbv_pulse", wb_valid, 0);

        // Store: read data must not change
        run_mem("st", 1'b1, 2'b00, 32'h200, 32'h1234, 5'd0, 2, 32'h5555_5555, 2);
        chk("st_rdata_hold", read_data_out, 32'hDEAD_BEEF);
        tick();

        // Ready and timeout coincide on the 4th WAIT cycle: ready wins
        run_mem("race", 1'b0, 2'b11, 32'h180, 32'h0, 5'd7, 4, 32'h0BAD_F00D, 4);
        chk("race_rdata", read_data_out, 32'h0BAD_F00D);
        tick();

        // Timeout: ready never comes
        ex_valid      = 1'b1;
        control_wb_in = 2'b11;
        memread_in    = 1'b1;
        alu_result_in = 32'h300;
        write_reg_in  = 5'd9;
        req_cycles    = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!dmem_req) break;
            req_cycles++;
            if (!stall) idle_inputs();
        end
        chk("to_req_cycles", req_cycles, 4);
        chk("to_req_off", dmem_req, 0);
        chk("to_err", mem_err, 1);
        chk("to_wbv", wb_valid, 1);
        chk("to_ctrl", control_wb_out, 2'b00);
        chk("to_rdata_hold", read_data_out, 32'h0BAD_F00D);
        idle_inputs();
        tick();
        chk("to_err_pulse", mem_err, 0);

        // Reset while waiting aborts the access silently
        ex_valid      = 1'b1;
        control_wb_in = 2'b11;
        memread_in    = 1'b1;
        alu_result_in = 32'h400;
        write_reg_in  = 5'd4;
        tick();
        chk("rw_req_on", dmem_req, 1);
        rst_n = 1'b0;
        idle_inputs();
        tick();
        chk("rw_req_off", dmem_req, 0);
        chk("rw_wbv", wb_valid, 0);
        chk("rw_err", mem_err, 0);
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        tick();
        chk("idle_ready_ign", wb_valid, 0);
        dmem_ready = 1'b0;
        run_mem("rw_ld", 1'b0, 2'b11, 32'h404, 32'h0, 5'd4, 1, 32'hCAFE_F00D, 1);
        chk("rw_ld_rdata", read_data_out, 32'hCAFE_F00D);
        tick();

`ifdef MEM_ALIGN_CHECK_EN
        ex_valid      = 1'b1;
        control_wb_in = 2'b11;
        memread_in    = 1'b1;
        alu_result_in = 32'h102;
        write_reg_in  = 5'd6;
        #1;
        chk("mis_stall", stall, 0);
        tick();
        idle_inputs();
        chk("mis_req", dmem_req, 0);
        chk("mis_err", mem_err, 1);
        chk("mis_wbv", wb_valid, 1);
        chk("mis_ctrl", control_wb_out, 2'b00);
`else
        run_mem("mis", 1'b0, 2'b11, 32'h102, 32'h0, 5'd6, 1, 32'h1357_9BDF, 1);
        chk("mis_rdata", read_data_out, 32'h1357_9BDF);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
